// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module  : multdiv_pkg
// Brief   : Shared types/constants for the iterative multiply/divide unit.
//           MULTDIV_BOOTH4_EN selects radix-4 Booth multiply (halves Nmul).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam logic [MD_WIDTH-1:0] MD_INT_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int nmul_iters(input int width);
`ifdef MULTDIV_BOOTH4_EN
        return width / 2;
`else
        return width;
`endif
    endfunction

    localparam int MD_NMUL = nmul_iters(MD_WIDTH);

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division step on magnitudes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,      // partial remainder with next dividend bit shifted in
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH-1:0] w_diff;

    // When the subtraction succeeds the true difference is below the divisor,
    // so the low WIDTH bits of the difference are exact.
    assign o_q_bit = (i_rem >= {1'b0, i_divisor});
    assign w_diff  = i_rem[WIDTH-1:0] - i_divisor;
    assign o_rem   = o_q_bit ? w_diff : i_rem[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// Module  : multdiv_unit
// Brief   : Iterative signed multiply/divide unit for the X stage; drives the
//           inProg/resultRDY stall handshake. Macro: MULTDIV_BOOTH4_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH     = MD_WIDTH,
    parameter int DIV_ITERS = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             inProg,
    output logic             resultRDY
);

    localparam int CW    = $clog2(WIDTH) + 1;
    localparam int N_MUL = nmul_iters(WIDTH);
    localparam logic [CW-1:0] C_MUL_LAST = CW'(N_MUL - 1);
    localparam logic [CW-1:0] C_DIV_LAST = CW'(DIV_ITERS - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 neg_q, neg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 exc_q, exc_d;

    logic [2*WIDTH-1:0]   w_mcand_init, w_mcand_next, w_acc_next, w_prod;
    logic [WIDTH:0]       w_mplier_init, w_mplier_next;
    logic                 w_mul_ovf;
    logic [WIDTH:0]       w_rem_in;
    logic [WIDTH-1:0]     w_rem_next, w_quo, w_quo_s;
    logic                 w_q_bit;

`ifdef MULTDIV_BOOTH4_EN
    logic [2*WIDTH-1:0]   w_pp;

    assign w_mcand_init  = {{WIDTH{operandA[WIDTH-1]}}, operandA};
    assign w_mplier_init = {operandB, 1'b0};

    // Booth digit from the overlapping triplet; operands stay signed throughout.
    always_comb begin
        w_pp = '0;
        case (mplier_q[2:0])
            3'b001, 3'b010: w_pp = mcand_q;
            3'b011:         w_pp = mcand_q << 1;
            3'b100:         w_pp = -(mcand_q << 1);
            3'b101, 3'b110: w_pp = -mcand_q;
            default:        w_pp = '0;
        endcase
        w_acc_next    = acc_q + w_pp;
        w_mcand_next  = mcand_q << 2;
        w_mplier_next = {{2{mplier_q[WIDTH]}}, mplier_q[WIDTH:2]};
        w_prod        = w_acc_next;
    end
`else
    assign w_mcand_init  = {{WIDTH{1'b0}}, magnitude(operandA)};
    assign w_mplier_init = {1'b0, magnitude(operandB)};

    always_comb begin
        w_acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);
        w_mcand_next  = mcand_q << 1;
        w_mplier_next = mplier_q >> 1;
        w_prod        = neg_q ? -w_acc_next : w_acc_next;
    end
`endif

    // Representable iff the top WIDTH+1 product bits are a pure sign extension.
    assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));

    assign w_rem_in = {rem_q, dvd_q[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (w_rem_in),
        .i_divisor (dvs_q),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    assign w_quo   = {dvd_q[WIDTH-2:0], w_q_bit};
    assign w_quo_s = neg_q ? -w_quo : w_quo;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                neg_d   = operandA[WIDTH-1] ^ operandB[WIDTH-1];
                if (ctrl_MULT) begin
                    state_d  = ST_MUL;
                    mcand_d  = w_mcand_init;
                    mplier_d = w_mplier_init;
                    acc_d    = '0;
                end else if (ctrl_DIV) begin
                    state_d = ST_DIV;
                    dvd_d   = magnitude(operandA);
                    dvs_d   = magnitude(operandB);
                    rem_d   = '0;
                    dz_d    = (operandB == '0);
                end
            end
            ST_MUL: begin
                acc_d    = w_acc_next;
                mcand_d  = w_mcand_next;
                mplier_d = w_mplier_next;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == C_MUL_LAST) begin
                    state_d  = ST_DONE;
                    result_d = w_prod[WIDTH-1:0];
                    exc_d    = w_mul_ovf;
                end
            end
            ST_DIV: begin
                rem_d = w_rem_next;
                dvd_d = w_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_DIV_LAST) begin
                    state_d  = ST_DONE;
                    // Only INT_MIN / -1 yields a positive quotient with the top bit set.
                    result_d = dz_q ? '0 : w_quo_s;
                    exc_d    = dz_q | (~neg_q & w_quo[WIDTH-1]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign inProg    = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign resultRDY = (state_q == ST_DONE);
    assign result    = result_q;
    assign exception = exc_q;

endmodule

`default_nettype wire
